// File: rtl/fp8_accum.sv
// FP8 (E4M3) sum-of-products accumulator: exact fixed-point accumulation of
// signed terms, normalised back to a single FP8 word on the last term.
module fp8_accum #(
  parameter int ACC_W = 24,
  parameter int BIAS  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_flags,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {ACC, NORM, OUT} state_t;

  // Accumulator LSB weighs 2^-FRAC_W; {1,M} carries three fraction bits.
  localparam int FRAC_W    = 9;
  localparam int SHIFT_OFF = BIAS + 3 - FRAC_W;
  localparam int EXP_OFF   = FRAC_W - BIAS;
  localparam int PW        = $clog2(ACC_W);
  localparam logic signed [ACC_W:0] MAX_POS = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_NEG = -MAX_POS;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [7:0]         out_data_q, out_data_d;
  logic [1:0]         out_flags_q, out_flags_d;
  logic               out_valid_q, out_valid_d;

  logic [3:0]         exp_in;
  logic [17:0]        term_mag;
  logic [ACC_W-1:0]   term_ext, term_s;
  logic signed [ACC_W:0] sum_s;

  logic [ACC_W-1:0]   mag;
  logic [PW-1:0]      lead;
  logic [3:0]         exp_o;
  logic [2:0]         mant_o;
  logic               sign_o;

  always_comb begin
    exp_in   = in_data[6:3];
    term_mag = '0;
    if (exp_in != 4'd0)
      term_mag = 18'({1'b1, in_data[2:0]}) << (exp_in - 4'(SHIFT_OFF));
    term_ext = {{(ACC_W-18){1'b0}}, term_mag};
    term_s   = in_data[7] ? -term_ext : term_ext;
    sum_s    = $signed({acc_q[ACC_W-1], acc_q}) + $signed({term_s[ACC_W-1], term_s});
  end

  // Saturation keeps |acc| <= 2^(ACC_W-1)-1, so negation here never overflows.
  always_comb begin
    sign_o = acc_q[ACC_W-1];
    mag    = sign_o ? -acc_q : acc_q;
    lead   = '0;
    for (int i = 0; i < ACC_W; i++)
      if (mag[i]) lead = PW'(i);
    exp_o  = 4'(lead - PW'(EXP_OFF));
    mant_o = 3'(mag >> (lead - PW'(3)));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    out_valid_d = out_valid_q;
    in_ready    = (state_q == ACC);
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (sum_s > MAX_POS) begin
            acc_d = MAX_POS[ACC_W-1:0];
            sat_d = 1'b1;
          end else if (sum_s < MIN_NEG) begin
            acc_d = MIN_NEG[ACC_W-1:0];
            sat_d = 1'b1;
          end else begin
            acc_d = sum_s[ACC_W-1:0];
          end
          if (in_last) state_d = NORM;
        end
      end
      NORM: begin
        if (mag == '0) begin
          out_data_d  = 8'h00;
          out_flags_d = 2'b00;
        end else if (mag < ACC_W'(8)) begin
          out_data_d  = 8'h00;
          out_flags_d = 2'b10;
        end else if (lead > PW'(15 + EXP_OFF) || sat_q) begin
          out_data_d  = {sign_o, 7'h7F};
          out_flags_d = 2'b01;
        end else begin
          out_data_d  = {sign_o, exp_o, mant_o};
          out_flags_d = 2'b00;
        end
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          sat_d       = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fp8_accum.sv
// Directed self-checking bench for fp8_accum: sums, flags, latency,
// output backpressure and reset in the middle of a sum or pending result.
module tb_fp8_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic [1:0] out_flags;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  fp8_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Drives a sum of n terms, waits for the result and optionally accepts it.
  task automatic run_sum(input logic [7:0] t [4], input int n, input bit accept,
                         output logic [7:0] d, output logic [1:0] f, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 10 && !in_ready; k++) begin
        @(posedge clk); #1;
      end
      if (!in_ready) ok = 1'b0;
      in_data  = t[i];
      in_last  = (i == n - 1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    for (int k = 0; k < 10 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    if (!out_valid) ok = 1'b0;
    d = out_data;
    f = out_flags;
    if (accept && out_valid) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00 || out_flags !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_out got %h/%b want 00/00", out_data, out_flags);
    end
  endtask

  task automatic test_latency();
    in_data = 8'h38; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL latency_norm got valid=%b ready=%b want 0/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL latency_out got valid=%b want 1", out_valid);
    end
    checks++;
    if (out_data !== 8'h38 || out_flags !== 2'b00) begin
      errors++; $display("[TB] FAIL latency_data got %h/%b want 38/00", out_data, out_flags);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_sums();
    logic [7:0] tv [10][4] = '{
      '{8'h38, 8'h38, 8'h00, 8'h00},
      '{8'h3C, 8'hB8, 8'h00, 8'h00},
      '{8'h08, 8'h88, 8'h00, 8'h00},
      '{8'h09, 8'h88, 8'h00, 8'h00},
      '{8'h7F, 8'h7F, 8'h7F, 8'h00},
      '{8'hFF, 8'hFF, 8'hFF, 8'h00},
      '{8'h38, 8'h00, 8'h00, 8'h00},
      '{8'hC4, 8'h00, 8'h00, 8'h00},
      '{8'h38, 8'h30, 8'h28, 8'h00},
      '{8'h3F, 8'h08, 8'h00, 8'h00}};
    int         tn [10] = '{2, 2, 2, 2, 3, 3, 2, 1, 3, 2};
    logic [7:0] ed [10] = '{8'h40, 8'h30, 8'h00, 8'h00, 8'h7F, 8'hFF, 8'h38, 8'hC4, 8'h3E, 8'h3F};
    logic [1:0] ef [10] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [7:0] d;
    logic [1:0] f;
    bit         ok;
    for (int v = 0; v < 10; v++) begin
      run_sum(tv[v], tn[v], 1'b1, d, f, ok);
      checks++;
      if (!ok || d !== ed[v] || f !== ef[v]) begin
        errors++;
        $display("[TB] FAIL sum_%0d got %h/%b (done=%b) want %h/%b", v, d, f, ok, ed[v], ef[v]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] t [4] = '{8'h3C, 8'h00, 8'h00, 8'h00};
    logic [7:0] one [4] = '{8'h38, 8'h00, 8'h00, 8'h00};
    logic [7:0] d;
    logic [1:0] f;
    bit         ok;
    run_sum(t, 1, 1'b0, d, f, ok);
    checks++;
    if (!ok || d !== 8'h3C) begin
      errors++; $display("[TB] FAIL bp_result got %h (done=%b) want 3c", d, ok);
    end
    in_data = 8'h38; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d got valid=%b data=%h ready=%b want 1/3c/0",
                 c, out_valid, out_data, in_ready);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    run_sum(one, 1, 1'b1, d, f, ok);
    checks++;
    if (!ok || d !== 8'h38 || f !== 2'b00) begin
      errors++; $display("[TB] FAIL bp_acc_cleared got %h/%b (done=%b) want 38/00", d, f, ok);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] two [4] = '{8'h38, 8'h38, 8'h00, 8'h00};
    logic [7:0] one [4] = '{8'h38, 8'h00, 8'h00, 8'h00};
    logic [7:0] d;
    logic [1:0] f;
    bit         ok;
    run_sum(two, 2, 1'b0, d, f, ok);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_out got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    in_data = 8'h7F; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_sum(one, 1, 1'b1, d, f, ok);
    checks++;
    if (!ok || d !== 8'h38 || f !== 2'b00) begin
      errors++; $display("[TB] FAIL rst_acc got %h/%b (done=%b) want 38/00", d, f, ok);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_latency();
    test_sums();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
